// File: rtl/fb_pkg.sv
// Shared types and default sizes for the cochlea feedback sequencer.
package fb_pkg;

    localparam int FB_CNT_W  = 16;
    localparam int FB_N_TAPS = 10;
    localparam int FB_GRAY_W = 19;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fb_state_t;

endpackage

// File: rtl/fb_tap_sched.sv
// Trailing-ones priority encoder: finds which gray bit toggles on the next phase step.
module fb_tap_sched #(
    parameter int N_TAPS = 10,
    parameter int K_W    = $clog2(N_TAPS + 2)
) (
    input  logic [N_TAPS:0]  ph_low,
    output logic [K_W-1:0]   tap_k,
    output logic             tap_valid
);

    // Lowest zero bit wins; all ones means the toggle lies above the tap range.
    always_comb begin
        tap_k = K_W'(N_TAPS + 1);
        for (int i = N_TAPS; i >= 0; i--) begin
            if (!ph_low[i]) begin
                tap_k = K_W'(i);
            end
        end
        tap_valid = (tap_k != '0) && (tap_k <= K_W'(N_TAPS));
    end

endmodule

// File: rtl/fb_sel_ctrl.sv
// Feedback path sequencer: up/down counter on a divided tick, gray phase, serialized tap output.
// Define FB_SAT_EN for a saturating counter; otherwise the counter wraps.
module fb_sel_ctrl
    import fb_pkg::*;
#(
    parameter int CNT_W  = FB_CNT_W,
    parameter int N_TAPS = FB_N_TAPS,
    parameter int GRAY_W = FB_GRAY_W,
    parameter int DIV    = 8
) (
    input  logic              clk_ext,
    input  logic              rst_ext,
    input  logic              start,
    input  logic              freeze,
    input  logic              stop,
    input  logic              ud,
    output logic [CNT_W-1:0]  count,
    output logic [GRAY_W-1:0] gray,
    output logic              tick,
    output logic              out_muxed,
    output logic              busy,
    output fb_state_t         dbg_state
);

    localparam int DIV_W = $clog2(DIV);
    localparam int K_W   = $clog2(N_TAPS + 2);
    localparam int IDX_W = $clog2(CNT_W);

    fb_state_t          state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [GRAY_W-1:0]  ph_q, ph_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               out_muxed_q, out_muxed_d;
    logic [K_W-1:0]     tap_k;
    logic               tap_valid;
    logic [IDX_W-1:0]   tap_idx;

    fb_tap_sched #(
        .N_TAPS (N_TAPS),
        .K_W    (K_W)
    ) u_tap_sched (
        .ph_low    (ph_q[N_TAPS:0]),
        .tap_k     (tap_k),
        .tap_valid (tap_valid)
    );

    assign busy      = (state_q != IDLE);
    assign tick      = busy && (div_q == DIV_W'(DIV - 1));
    assign tap_idx   = IDX_W'(CNT_W - int'(tap_k));
    assign count     = count_q;
    assign gray      = ph_q ^ (ph_q >> 1);
    assign out_muxed = out_muxed_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        ph_d        = ph_q;
        count_d     = count_q;
        out_muxed_d = out_muxed_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    div_d   = '0;
                end
            end
            RUN:     if (freeze)  state_d = HOLD;
            HOLD:    if (!freeze) state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (stop) begin
            state_d = IDLE;
        end

        // Mux samples the registered count, so a same-edge counter update is not seen.
        if (busy) begin
            ph_d  = ph_q + 1'b1;
            div_d = tick ? '0 : div_q + 1'b1;
            if (tap_valid) begin
                out_muxed_d = count_q[tap_idx];
            end
        end

        if (state_q == RUN && tick) begin
`ifdef FB_SAT_EN
            if (ud) begin
                count_d = (&count_q) ? count_q : count_q + 1'b1;
            end else begin
                count_d = (count_q == '0) ? count_q : count_q - 1'b1;
            end
`else
            count_d = ud ? count_q + 1'b1 : count_q - 1'b1;
`endif
        end
    end

    always_ff @(posedge clk_ext) begin
        if (rst_ext) begin
            state_q     <= IDLE;
            div_q       <= '0;
            ph_q        <= '0;
            count_q     <= '0;
            out_muxed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            ph_q        <= ph_d;
            count_q     <= count_d;
            out_muxed_q <= out_muxed_d;
        end
    end

endmodule

// File: tb/tb_fb_sel_ctrl.sv
// Directed-sequence bench for fb_sel_ctrl with a per-cycle expected-value queue.
module tb_fb_sel_ctrl;
    import fb_pkg::*;

    localparam int CNT_W  = 16;
    localparam int N_TAPS = 10;
    localparam int GRAY_W = 19;
    localparam int DIV    = 8;
    localparam int SB_W   = 2 + 3 + GRAY_W + CNT_W;

    logic              clk_ext = 1'b0;
    logic              rst_ext = 1'b1;
    logic              start = 1'b0;
    logic              freeze = 1'b0;
    logic              stop = 1'b0;
    logic              ud = 1'b0;
    logic [CNT_W-1:0]  count;
    logic [GRAY_W-1:0] gray;
    logic              tick;
    logic              out_muxed;
    logic              busy;
    fb_state_t         dbg_state;

    fb_sel_ctrl #(
        .CNT_W  (CNT_W),
        .N_TAPS (N_TAPS),
        .GRAY_W (GRAY_W),
        .DIV    (DIV)
    ) dut (
        .clk_ext   (clk_ext),
        .rst_ext   (rst_ext),
        .start     (start),
        .freeze    (freeze),
        .stop      (stop),
        .ud        (ud),
        .count     (count),
        .gray      (gray),
        .tick      (tick),
        .out_muxed (out_muxed),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk_ext = ~clk_ext;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cycle  = 0;
    logic [SB_W-1:0] exp_q[$];

    // Reference model state: 0 = idle, 1 = run, 2 = hold
    int                m_state = 0;
    int                m_div   = 0;
    logic [GRAY_W-1:0] m_ph    = '0;
    logic [CNT_W-1:0]  m_cnt   = '0;
    logic              m_out   = 1'b0;

    function automatic logic [GRAY_W-1:0] to_gray(input int v);
        logic [GRAY_W-1:0] b;
        b = GRAY_W'(v);
        return b ^ (b >> 1);
    endfunction

    task automatic model_edge(input logic s, input logic f, input logic p, input logic u, input logic r);
        logic tk;
        int   tz;
        tk = (m_state != 0) && (m_div == DIV - 1);
        if (r) begin
            m_state = 0; m_div = 0; m_ph = '0; m_cnt = '0; m_out = 1'b0;
        end else begin
            tz = 0;
            while (tz < GRAY_W && m_ph[tz]) tz++;
            if (m_state != 0 && tz >= 1 && tz <= N_TAPS) m_out = m_cnt[CNT_W - tz];
            if (m_state == 1 && tk) begin
`ifdef FB_SAT_EN
                if (u && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
                else if (!u && m_cnt != 16'h0000) m_cnt = m_cnt - 1;
`else
                m_cnt = u ? m_cnt + 1 : m_cnt - 1;
`endif
            end
            if (m_state != 0) begin
                m_ph  = m_ph + 1;
                m_div = tk ? 0 : m_div + 1;
            end
            if (p) m_state = 0;
            else if (m_state == 0 && s) begin m_state = 1; m_div = 0; end
            else if (m_state == 1 && f) m_state = 2;
            else if (m_state == 2 && !f) m_state = 1;
        end
    endtask

    function automatic logic [SB_W-1:0] model_pack();
        logic bz;
        bz = (m_state != 0);
        return {2'(m_state), bz, bz && (m_div == DIV - 1), m_out, to_gray(int'(m_ph)), m_cnt};
    endfunction

    task automatic step(input logic s, input logic f, input logic p, input logic u, input logic r);
        logic [SB_W-1:0] obs;
        logic [SB_W-1:0] exp;
        start = s; freeze = f; stop = p; ud = u; rst_ext = r;
        model_edge(s, f, p, u, r);
        exp_q.push_back(model_pack());
        @(posedge clk_ext);
        #1;
        n_cycle++;
        exp = exp_q.pop_front();
        obs = {2'(dbg_state), busy, tick, out_muxed, gray, count};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL cycle%0d obs=%h exp=%h", n_cycle, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [SB_W-1:0] obs, input logic [SB_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset and idle
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("rst_count", SB_W'(count), SB_W'(0));
        chk("rst_gray", SB_W'(gray), SB_W'(0));
        chk("rst_out", SB_W'(out_muxed), SB_W'(0));
        chk("rst_busy", SB_W'(busy), SB_W'(0));
        chk("rst_tick", SB_W'(tick), SB_W'(0));
        chk("rst_state", SB_W'(dbg_state), SB_W'(IDLE));
        repeat (3) step(0, 0, 0, 1, 0);

        // Count up 10 ticks
        step(1, 0, 0, 1, 0);
        chk("start_busy", SB_W'(busy), SB_W'(1));
        repeat (10 * DIV) step(0, 0, 0, 1, 0);
        chk("count_10", SB_W'(count), SB_W'(10));

        // Freeze: counter holds, phase advances
        repeat (5 * DIV) step(0, 1, 0, 1, 0);
        chk("freeze_count", SB_W'(count), SB_W'(10));
        chk("freeze_gray", SB_W'(gray), SB_W'(to_gray(15 * DIV)));
        chk("freeze_state", SB_W'(dbg_state), SB_W'(HOLD));
        repeat (2 * DIV) step(0, 0, 0, 1, 0);
        chk("resume_count", SB_W'(count), SB_W'(12));

        // Lower bound, then back up
        repeat (14 * DIV) step(0, 0, 0, 0, 0);
`ifdef FB_SAT_EN
        chk("low_bound", SB_W'(count), SB_W'(16'h0000));
        repeat (DIV) step(0, 0, 0, 1, 0);
        chk("up_1", SB_W'(count), SB_W'(16'h0001));
        repeat (DIV) step(0, 0, 0, 1, 0);
        chk("up_2", SB_W'(count), SB_W'(16'h0002));
        repeat (DIV) step(0, 0, 0, 1, 0);
        chk("up_3", SB_W'(count), SB_W'(16'h0003));
`else
        chk("low_bound", SB_W'(count), SB_W'(16'hFFFE));
        repeat (DIV) step(0, 0, 0, 1, 0);
        chk("up_1", SB_W'(count), SB_W'(16'hFFFF));
        repeat (DIV) step(0, 0, 0, 1, 0);
        chk("up_2", SB_W'(count), SB_W'(16'h0000));
        repeat (DIV) step(0, 0, 0, 1, 0);
        chk("up_3", SB_W'(count), SB_W'(16'h0001));
`endif

        // Long run so every tap and the k > N_TAPS hold case are exercised
        repeat (1200) step(0, 0, 0, 0, 0);
        repeat (1200) step(0, ($urandom_range(0, 9) == 0), 0, 1'($urandom_range(0, 1)), 0);

        // start and stop together: stop wins
        step(0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("startstop_busy", SB_W'(busy), SB_W'(0));
        chk("startstop_state", SB_W'(dbg_state), SB_W'(IDLE));
        repeat (3) step(0, 0, 0, 0, 0);

        // Restart: first tick exactly DIV edges after the start edge
        step(1, 0, 0, 0, 0);
        repeat (DIV - 2) step(0, 0, 0, 0, 0);
        chk("pre_tick", SB_W'(tick), SB_W'(0));
        step(0, 0, 0, 0, 0);
        chk("first_tick", SB_W'(tick), SB_W'(1));

        // Reset while in HOLD
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("hold_state", SB_W'(dbg_state), SB_W'(HOLD));
        step(0, 1, 0, 0, 1);
        chk("hrst_count", SB_W'(count), SB_W'(0));
        chk("hrst_gray", SB_W'(gray), SB_W'(0));
        chk("hrst_out", SB_W'(out_muxed), SB_W'(0));
        chk("hrst_busy", SB_W'(busy), SB_W'(0));
        chk("hrst_state", SB_W'(dbg_state), SB_W'(IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
